uart_tx_arbiter: RTL and testbench

//  Shares one uart_transmitter between NUM_REQ byte producers using round-robin arbitration.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 tb/tb_uart_tx_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path: arbiter FSM state
//   encodings, default frame timing (one bit per clk: start + 8 data + stop)
//   and a helper that sizes index fields so a single requester still gets a
//   1-bit field.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int DEF_FRAME_CYCLES = 10;
    localparam int DEF_GAP_CYCLES   = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundle between the byte producers / uart_transmitter and the arbiter.
//   req_valid/req_data/req_ready : per-requester byte handshake
//                                  (byte i in req_data[i*DATA_W +: DATA_W])
//   load/data                    : start pulse and byte to the transmitter
//   busy                         : frame (plus gap) in progress
//   grant_id                     : index of the last accepted requester
//   slave  modport : arbiter side
//   master modport : producer / transmitter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      load;
    logic [DATA_W-1:0]         data;
    logic                      busy;
    logic [IDX_W-1:0]          grant_id;

    modport slave (
        input  req_valid, req_data,
        output req_ready, load, data, busy, grant_id
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, load, data, busy, grant_id
    );
endinterface

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
//   Combinational round-robin pick: the first asserted request found when
//   searching i_ptr, i_ptr+1, ... with wrap modulo NUM_REQ.
//   i_req_valid : pending requests
//   i_ptr       : highest-priority index this cycle (always < NUM_REQ)
//   o_grant     : one-hot winner (zero when nothing is pending)
//   o_idx       : winner index
//   o_any       : at least one request pending
// ---------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    int w_j;

    // Walk from the lowest priority offset up to offset 0 so the nearest
    // pending request to i_ptr overwrites any farther one.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (i_req_valid[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
                o_any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_transmitter between NUM_REQ byte producers with
//   round-robin arbitration. The transmitter reports no busy state, so the
//   frame and the trailing gap are timed here.
//   clk : clock, posedge
//   rst : synchronous active-high reset
//   bus : slave side of uart_tx_arbiter_if (requester handshake, load/data
//         to the transmitter, busy, grant_id)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

    // WAIT starts one cycle after LOAD, so it ends FRAME_CYCLES-2 counts in.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FRAME_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_grant_id;

    logic [1:0]         w_next_state;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_handshake;
    logic [IDX_W-1:0]   w_ptr_next;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req_valid (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_handshake = (r_state == ST_IDLE) && w_any && !rst;
    assign w_ptr_next  = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_WAIT;
            ST_WAIT: if (r_cnt == WAIT_LAST) w_next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (r_cnt == GAP_LAST) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_data     <= '0;
            r_grant_id <= '0;
        end else begin
            r_state <= w_next_state;
            // Counter only runs inside WAIT/GAP and restarts on each state
            // change, so it never needs to wrap.
            if (w_next_state != r_state || r_state == ST_IDLE || r_state == ST_LOAD)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_handshake) begin
                r_data     <= bus.req_data[int'(w_idx)*DATA_W +: DATA_W];
                r_grant_id <= w_idx;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE && !rst) ? w_grant : '0;
    assign bus.load      = (r_state == ST_LOAD);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.data      = r_data;
    assign bus.grant_id  = r_grant_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter: a default build (NUM_REQ=4,
//   FRAME=10, GAP=1) and a GAP_CYCLES=0 build sharing clk/rst.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus0 ();
    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus1 ();

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .FRAME_CYCLES(10), .GAP_CYCLES(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .FRAME_CYCLES(10), .GAP_CYCLES(0)
    ) dut_nogap (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge: start of the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; returns at the start of cycle 0 with rst low.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        bus1.req_valid = '0;
        bus1.req_data  = '0;

        // Reset with every requester pending
        bus0.req_valid = 4'b1111;
        bus0.req_data  = 32'h13121110;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst ready %0d", i), 32'(bus0.req_ready), 32'h0);
            check($sformatf("rst load %0d", i), 32'(bus0.load), 32'h0);
            check($sformatf("rst busy %0d", i), 32'(bus0.busy), 32'h0);
            check($sformatf("rst data %0d", i), 32'(bus0.data), 32'h0);
            check($sformatf("rst grant %0d", i), 32'(bus0.grant_id), 32'h0);
        end
        rst = 1'b0;
        #1;
        check("rst release ready", 32'(bus0.req_ready), 32'h1);

        // Single request from requester 2
        bus0.req_valid = '0;
        do_reset();
        bus0.req_valid = 4'b0100;
        bus0.req_data  = 32'h00AA0000;
        #1;
        check("single ready c0", 32'(bus0.req_ready), 32'h4);
        step();
        bus0.req_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            check($sformatf("single load c%0d", c), 32'(bus0.load), (c == 1) ? 32'h1 : 32'h0);
            check($sformatf("single busy c%0d", c), 32'(bus0.busy), (c <= 11) ? 32'h1 : 32'h0);
            if (c <= 10) check($sformatf("single data c%0d", c), 32'(bus0.data), 32'hAA);
            if (c == 1) check("single grant", 32'(bus0.grant_id), 32'h2);
            if (c == 12) begin
                bus0.req_valid = 4'b0100;
                #1;
                check("single rearm c12", 32'(bus0.req_ready), 32'h4);
                bus0.req_valid = '0;
            end
            step();
        end

        // All four continuously valid: 0,1,2,3,0 every 12 cycles
        do_reset();
        bus0.req_valid = 4'b1111;
        bus0.req_data  = 32'h13121110;
        for (int c = 0; c <= 48; c++) begin
            #1;
            exp_rdy = (c % 12 == 0) ? (4'b0001 << ((c / 12) % 4)) : 4'b0000;
            check($sformatf("rr ready c%0d", c), 32'(bus0.req_ready), 32'(exp_rdy));
            check($sformatf("rr load c%0d", c), 32'(bus0.load), (c % 12 == 1) ? 32'h1 : 32'h0);
            if (c % 12 == 1) begin
                check($sformatf("rr data c%0d", c), 32'(bus0.data), 32'h10 + 32'((c / 12) % 4));
                check($sformatf("rr grant c%0d", c), 32'(bus0.grant_id), 32'((c / 12) % 4));
            end
            if (c < 48) step();
        end

        // Fairness between requesters 1 and 3 after a grant to 1
        bus0.req_valid = '0;
        do_reset();
        bus0.req_valid = 4'b0010;
        bus0.req_data  = 32'hD3C2B1A0;
        #1;
        check("fair ready c0", 32'(bus0.req_ready), 32'h2);
        step();
        bus0.req_valid = 4'b1010;
        for (int c = 1; c <= 37; c++) begin
            #1;
            case (c)
                12:      exp_rdy = 4'b1000;
                24:      exp_rdy = 4'b0010;
                36:      exp_rdy = 4'b1000;
                default: exp_rdy = 4'b0000;
            endcase
            check($sformatf("fair ready c%0d", c), 32'(bus0.req_ready), 32'(exp_rdy));
            if (c == 1)  check("fair grant c1", 32'(bus0.grant_id), 32'h1);
            if (c == 13) check("fair grant c13", 32'(bus0.grant_id), 32'h3);
            if (c == 25) check("fair grant c25", 32'(bus0.grant_id), 32'h1);
            if (c == 37) begin
                check("fair grant c37", 32'(bus0.grant_id), 32'h3);
                check("fair data c37", 32'(bus0.data), 32'hD3);
            end
            if (c < 37) step();
        end

        // Reset in the middle of a frame
        bus0.req_valid = '0;
        do_reset();
        bus0.req_valid = 4'b0001;
        bus0.req_data  = 32'h0000005A;
        #1;
        check("midrst ready c0", 32'(bus0.req_ready), 32'h1);
        for (int c = 1; c <= 5; c++) step();
        check("midrst busy c5", 32'(bus0.busy), 32'h1);
        rst = 1'b1;
        step();
        check("midrst busy c6", 32'(bus0.busy), 32'h0);
        check("midrst load c6", 32'(bus0.load), 32'h0);
        check("midrst data c6", 32'(bus0.data), 32'h0);
        rst = 1'b0;
        #1;
        check("midrst ready c6", 32'(bus0.req_ready), 32'h1);

        // GAP_CYCLES=0 build: back-to-back frames 11 cycles apart
        bus0.req_valid = '0;
        do_reset();
        bus1.req_valid = 4'b0011;
        bus1.req_data  = 32'h00002211;
        for (int c = 0; c <= 12; c++) begin
            #1;
            exp_rdy = (c == 0) ? 4'b0001 : ((c == 11) ? 4'b0010 : 4'b0000);
            check($sformatf("nogap ready c%0d", c), 32'(bus1.req_ready), 32'(exp_rdy));
            check($sformatf("nogap load c%0d", c), 32'(bus1.load),
                  (c == 1 || c == 12) ? 32'h1 : 32'h0);
            if (c == 12) check("nogap data c12", 32'(bus1.data), 32'h22);
            if (c < 12) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
